// File: rtl/lane_chart_reader.sv
// Per-lane chart reader: walks the chart ROM, keeps song time, judges
// presses/releases against the head note and flags upcoming visible notes.
module lane_chart_reader #(
  parameter int unsigned NOTE_COUNT  = 256,
  parameter int unsigned PERFECT_WIN = 3,
  parameter int unsigned GOOD_WIN    = 8,
  parameter int unsigned LEAD        = 120
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        frame_tick,
  input  logic        key,
  input  logic [15:0] key_1,
  input  logic [15:0] key_2,
  input  logic [15:0] key_3,
  input  logic [15:0] key_4,
  output logic [7:0]  addr,
  output logic [13:0] song_time,
  output logic [3:0]  visible,
  output logic        holding,
  output logic        perfect,
  output logic        good,
  output logic        miss,
  output logic [9:0]  combo,
  output logic [9:0]  max_combo,
  output logic        done
);

  localparam int unsigned AW = 9;
  localparam int unsigned TW = 14;
  localparam int unsigned DW = 15;
  localparam int unsigned CW = 10;

  localparam logic [AW-1:0]        NOTE_END  = AW'(NOTE_COUNT);
  localparam logic [DW-1:0]        PERF_U    = DW'(PERFECT_WIN);
  localparam logic [DW-1:0]        GOOD_U    = DW'(GOOD_WIN);
  localparam logic signed [DW-1:0] GOOD_S    = $signed(DW'(GOOD_WIN));
  localparam logic [DW-1:0]        LEAD_U    = DW'(LEAD);
  localparam logic [TW-1:0]        TIME_MAX  = {TW{1'b1}};
  localparam logic [CW-1:0]        COMBO_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [TW-1:0]  song_q, song_d;
  logic [3:0]     vis_q, vis_d;
  logic           holding_q, holding_d;
  logic           perfect_q, perfect_d;
  logic           good_q, good_d;
  logic           miss_q, miss_d;
  logic [CW-1:0]  combo_q, combo_d;
  logic [CW-1:0]  max_q, max_d;
  logic           done_q, done_d;
  logic           key_q, key_d;

  logic [1:0]            typ;
  logic [TW-1:0]         t;
  logic signed [DW-1:0]  d;
  logic signed [DW-1:0]  d_neg;
  logic [DW-1:0]         mag;
  logic                  press;
  logic                  release_ev;
  logic [TW-1:0]         song_inc;
  logic [15:0]           win [4];
  logic [AW-1:0]         idx;
  logic [DW-1:0]         horizon;

  assign addr      = addr_q[7:0];
  assign song_time = song_q;
  assign visible   = vis_q;
  assign holding   = holding_q;
  assign perfect   = perfect_q;
  assign good      = good_q;
  assign miss      = miss_q;
  assign combo     = combo_q;
  assign max_combo = max_q;
  assign done      = done_q;

  // Next-state, judgement, combo and visibility logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    song_d    = song_q;
    combo_d   = combo_q;
    max_d     = max_q;
    key_d     = key;
    perfect_d = 1'b0;
    good_d    = 1'b0;
    miss_d    = 1'b0;
    vis_d     = 4'b0000;
    idx       = '0;

    typ        = key_1[15:14];
    t          = key_1[13:0];
    d          = $signed({1'b0, song_q}) - $signed({1'b0, t});
    d_neg      = -d;
    mag        = d[DW-1] ? DW'(d_neg) : DW'(d);
    press      = key & ~key_q;
    release_ev = ~key & key_q;
    song_inc   = (song_q == TIME_MAX) ? song_q : song_q + TW'(1);
    horizon    = {1'b0, song_q} + LEAD_U;
    win[0]     = key_1;
    win[1]     = key_2;
    win[2]     = key_3;
    win[3]     = key_4;

    if (start) begin
      state_d = S_PLAY;
      addr_d  = '0;
      song_d  = '0;
      combo_d = '0;
      max_d   = '0;
      key_d   = 1'b0;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (frame_tick) song_d = song_inc;
          if (addr_q >= NOTE_END || typ == 2'b11) begin
            state_d = S_DONE;
          end else if (typ == 2'b10) begin
            addr_d = addr_q + AW'(1);
          end else if (d > GOOD_S) begin
            miss_d = 1'b1;
            addr_d = addr_q + ((typ == 2'b01) ? AW'(2) : AW'(1));
          end else if (press && mag <= GOOD_U) begin
            if (mag <= PERF_U) perfect_d = 1'b1;
            else               good_d    = 1'b1;
            addr_d = addr_q + AW'(1);
            if (typ == 2'b01) state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (frame_tick) song_d = song_inc;
          if (typ != 2'b10) begin
            state_d = S_PLAY;
          end else if (key && song_q >= t) begin
            perfect_d = 1'b1;
            addr_d    = addr_q + AW'(1);
            state_d   = S_PLAY;
          end else if (release_ev) begin
            if (d_neg <= GOOD_S) good_d = 1'b1;
            else                 miss_d = 1'b1;
            addr_d  = addr_q + AW'(1);
            state_d = S_PLAY;
          end
        end
        default: ;
      endcase
    end

    if (perfect_d || good_d) begin
      combo_d = (combo_q == COMBO_MAX) ? combo_q : combo_q + CW'(1);
      if (combo_d > max_q) max_d = combo_d;
    end else if (miss_d) begin
      combo_d = '0;
    end

    if (!start && (state_q == S_PLAY || state_q == S_HOLD) &&
        (state_d == S_PLAY || state_d == S_HOLD)) begin
      for (int i = 0; i < 4; i++) begin
        idx      = addr_q + AW'(i);
        vis_d[i] = (idx < NOTE_END) && (win[i][15:14] != 2'b11) &&
                   ({1'b0, win[i][13:0]} <= horizon);
      end
    end

    holding_d = (state_d == S_HOLD);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      song_q    <= '0;
      vis_q     <= '0;
      holding_q <= 1'b0;
      perfect_q <= 1'b0;
      good_q    <= 1'b0;
      miss_q    <= 1'b0;
      combo_q   <= '0;
      max_q     <= '0;
      done_q    <= 1'b0;
      key_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      song_q    <= song_d;
      vis_q     <= vis_d;
      holding_q <= holding_d;
      perfect_q <= perfect_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      combo_q   <= combo_d;
      max_q     <= max_d;
      done_q    <= done_d;
      key_q     <= key_d;
    end
  end

endmodule

// File: tb/tb_lane_chart_reader.sv
// Directed bench for lane_chart_reader with a small behavioural chart ROM.
module tb_lane_chart_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        frame_tick;
  logic        key;
  logic [15:0] key_1, key_2, key_3, key_4;
  logic [7:0]  addr;
  logic [13:0] song_time;
  logic [3:0]  visible;
  logic        holding, perfect, good, miss, done;
  logic [9:0]  combo, max_combo;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [8];

  lane_chart_reader #(
    .NOTE_COUNT(3), .PERFECT_WIN(3), .GOOD_WIN(8), .LEAD(120)
  ) dut (
    .Clk(clk), .Reset(rst), .start(start), .frame_tick(frame_tick), .key(key),
    .key_1(key_1), .key_2(key_2), .key_3(key_3), .key_4(key_4),
    .addr(addr), .song_time(song_time), .visible(visible), .holding(holding),
    .perfect(perfect), .good(good), .miss(miss), .combo(combo),
    .max_combo(max_combo), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM model; words past the table read as end markers.
  always_comb begin
    key_1 = (int'(addr) + 0 < 8) ? rom[int'(addr) + 0] : 16'hC000;
    key_2 = (int'(addr) + 1 < 8) ? rom[int'(addr) + 1] : 16'hC000;
    key_3 = (int'(addr) + 2 < 8) ? rom[int'(addr) + 2] : 16'hC000;
    key_4 = (int'(addr) + 3 < 8) ? rom[int'(addr) + 3] : 16'hC000;
  end

  task automatic load_rom(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    for (int i = 0; i < 8; i++) rom[i] = 16'hC000;
    rom[0] = a; rom[1] = b; rom[2] = c;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic advance_to(input int target);
    int n;
    n = target - int'(song_time);
    frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; frame_tick = 1'b0; key = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({addr, song_time, visible, holding, perfect, good, miss, combo, max_combo, done} !== '0) begin
      errors++; $display("FAIL reset_outputs: addr=%0d song=%0d vis=%b done=%b", addr, song_time, visible, done);
    end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
  endtask

  task automatic test_tap();
    load_rom(16'h0032, 16'h0064, 16'hC000);
    do_start();
    advance_to(51);
    key = 1'b1; @(negedge clk);
    checks++;
    if (perfect !== 1'b1 || good !== 1'b0 || miss !== 1'b0) begin
      errors++; $display("FAIL tap_perfect: p/g/m=%b%b%b exp 100", perfect, good, miss);
    end
    checks++;
    if (addr !== 8'd1 || combo !== 10'd1) begin
      errors++; $display("FAIL tap_perfect_state: addr=%0d combo=%0d exp 1 1", addr, combo);
    end
    key = 1'b0; @(negedge clk);
    checks++;
    if (perfect !== 1'b0) begin errors++; $display("FAIL tap_pulse_len: perfect=%b exp 0", perfect); end
    advance_to(109);
    checks++;
    if (miss !== 1'b0 || addr !== 8'd1) begin
      errors++; $display("FAIL tap_no_early_miss: miss=%b addr=%0d exp 0 1", miss, addr);
    end
    @(negedge clk);
    checks++;
    if (miss !== 1'b1 || combo !== 10'd0 || max_combo !== 10'd1 || addr !== 8'd2) begin
      errors++; $display("FAIL tap_miss_combo: miss=%b combo=%0d max=%0d addr=%0d exp 1 0 1 2", miss, combo, max_combo, addr);
    end
  endtask

  task automatic test_early_good();
    load_rom(16'h0032, 16'hC000, 16'hC000);
    do_start();
    advance_to(40);
    key = 1'b1; @(negedge clk);
    checks++;
    if ({perfect, good, miss} !== 3'b000 || addr !== 8'd0) begin
      errors++; $display("FAIL early_ignored: pgm=%b%b%b addr=%0d exp 000 0", perfect, good, miss, addr);
    end
    key = 1'b0; @(negedge clk);
    advance_to(44);
    key = 1'b1; @(negedge clk);
    checks++;
    if (good !== 1'b1 || perfect !== 1'b0 || addr !== 8'd1 || combo !== 10'd1) begin
      errors++; $display("FAIL good_press: good=%b perfect=%b addr=%0d combo=%0d exp 1 0 1 1", good, perfect, addr, combo);
    end
    key = 1'b0; @(negedge clk);
  endtask

  task automatic test_late_miss();
    load_rom(16'h0032, 16'hC000, 16'hC000);
    do_start();
    advance_to(59);
    checks++;
    if (miss !== 1'b0 || addr !== 8'd0) begin
      errors++; $display("FAIL late_boundary: miss=%b addr=%0d exp 0 0", miss, addr);
    end
    @(negedge clk);
    checks++;
    if (miss !== 1'b1 || addr !== 8'd1 || combo !== 10'd0 || song_time !== 14'd59) begin
      errors++; $display("FAIL late_miss: miss=%b addr=%0d combo=%0d song=%0d exp 1 1 0 59", miss, addr, combo, song_time);
    end
  endtask

  task automatic test_hold_perfect();
    load_rom(16'h411A, 16'h8143, 16'hC000);
    do_start();
    advance_to(282);
    key = 1'b1; @(negedge clk);
    checks++;
    if (perfect !== 1'b1 || holding !== 1'b1 || addr !== 8'd1 || combo !== 10'd1) begin
      errors++; $display("FAIL hold_head: p=%b hold=%b addr=%0d combo=%0d exp 1 1 1 1", perfect, holding, addr, combo);
    end
    advance_to(323);
    checks++;
    if (holding !== 1'b1 || perfect !== 1'b0) begin
      errors++; $display("FAIL hold_during: hold=%b p=%b exp 1 0", holding, perfect);
    end
    @(negedge clk);
    checks++;
    if (perfect !== 1'b1 || holding !== 1'b0 || addr !== 8'd2 || combo !== 10'd2 || max_combo !== 10'd2) begin
      errors++; $display("FAIL hold_tail: p=%b hold=%b addr=%0d combo=%0d max=%0d exp 1 0 2 2 2", perfect, holding, addr, combo, max_combo);
    end
    key = 1'b0; @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL hold_end_done: done=%b exp 1", done); end
  endtask

  task automatic test_hold_release();
    do_start();
    advance_to(282);
    key = 1'b1; @(negedge clk);
    advance_to(300);
    key = 1'b0; @(negedge clk);
    checks++;
    if (miss !== 1'b1 || combo !== 10'd0 || max_combo !== 10'd1 || holding !== 1'b0 || addr !== 8'd2) begin
      errors++; $display("FAIL hold_release: miss=%b combo=%0d max=%0d hold=%b addr=%0d exp 1 0 1 0 2", miss, combo, max_combo, holding, addr);
    end
  endtask

  task automatic test_hold_nopress();
    do_start();
    advance_to(291);
    checks++;
    if (miss !== 1'b0) begin errors++; $display("FAIL hold_nopress_early: miss=%b exp 0", miss); end
    @(negedge clk);
    checks++;
    if (miss !== 1'b1 || addr !== 8'd2 || holding !== 1'b0) begin
      errors++; $display("FAIL hold_nopress: miss=%b addr=%0d hold=%b exp 1 2 0", miss, addr, holding);
    end
    @(negedge clk);
    checks++;
    if (miss !== 1'b0) begin errors++; $display("FAIL hold_single_miss: miss=%b exp 0", miss); end
  endtask

  task automatic test_done_restart();
    int times [3];
    times[0] = 5; times[1] = 10; times[2] = 15;
    load_rom(16'h0005, 16'h000A, 16'h000F);
    do_start();
    for (int i = 0; i < 3; i++) begin
      advance_to(times[i]);
      key = 1'b1; @(negedge clk);
      key = 1'b0; @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || visible !== 4'b0000 || combo !== 10'd3 || max_combo !== 10'd3) begin
      errors++; $display("FAIL done_state: done=%b vis=%b combo=%0d max=%0d exp 1 0000 3 3", done, visible, combo, max_combo);
    end
    key = 1'b1; @(negedge clk);
    checks++;
    if ({perfect, good, miss} !== 3'b000 || done !== 1'b1) begin
      errors++; $display("FAIL done_key_ignored: pgm=%b%b%b done=%b exp 000 1", perfect, good, miss, done);
    end
    key = 1'b0;
    do_start();
    checks++;
    if (song_time !== 14'd0 || addr !== 8'd0 || combo !== 10'd0 || max_combo !== 10'd0 || done !== 1'b0) begin
      errors++; $display("FAIL restart: song=%0d addr=%0d combo=%0d max=%0d done=%b exp 0 0 0 0 0", song_time, addr, combo, max_combo, done);
    end
  endtask

  task automatic test_visible();
    load_rom(16'h0032, 16'h003C, 16'h0082);
    do_start();
    @(negedge clk);
    checks++;
    if (visible !== 4'b0011) begin errors++; $display("FAIL visible_t0: got %b exp 0011", visible); end
    advance_to(10);
    checks++;
    if (visible !== 4'b0011) begin errors++; $display("FAIL visible_t9: got %b exp 0011", visible); end
    @(negedge clk);
    checks++;
    if (visible !== 4'b0111) begin errors++; $display("FAIL visible_t10: got %b exp 0111", visible); end
  endtask

  task automatic test_reset_mid_hold();
    load_rom(16'h411A, 16'h8143, 16'hC000);
    do_start();
    advance_to(282);
    key = 1'b1; @(negedge clk);
    checks++;
    if (holding !== 1'b1) begin errors++; $display("FAIL pre_reset_hold: hold=%b exp 1", holding); end
    rst = 1'b1; start = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    checks++;
    if ({addr, song_time, visible, holding, perfect, good, miss, combo, max_combo, done} !== '0) begin
      errors++; $display("FAIL reset_mid_hold: addr=%0d song=%0d hold=%b combo=%0d", addr, song_time, holding, combo);
    end
    rst = 1'b0; start = 1'b0; frame_tick = 1'b0; key = 1'b0;
    @(negedge clk);
    key = 1'b1; frame_tick = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({perfect, good, miss} !== 3'b000 || song_time !== 14'd0 || addr !== 8'd0 || holding !== 1'b0) begin
      errors++; $display("FAIL idle_ignores: pgm=%b%b%b song=%0d addr=%0d hold=%b", perfect, good, miss, song_time, addr, holding);
    end
    key = 1'b0; frame_tick = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 16'hC000;
    test_reset();
    test_tap();
    test_early_good();
    test_late_miss();
    test_hold_perfect();
    test_hold_release();
    test_hold_nopress();
    test_done_restart();
    test_visible();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
